// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder_arbiter slice: FSM state, output-stage record
// and a constant clog2 helper. The output record is sized by the package defaults.
package adder_arb_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_ID_W  = clog2(DEF_NREQ);

    typedef enum logic [0:0] {
        IDLE,
        LOCK
    } arb_state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 co;
        logic                 last;
        logic [DEF_ID_W-1:0]  id;
        logic                 ovf;
    } out_stage_t;

endpackage

// File: rtl/adder.sv
// Shared WIDTH-bit ripple-carry adder used as the arithmetic datapath.
module adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[WIDTH];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping,
// plus the encoded index of the winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Upper half (ptr..NREQ-1) first, then wrap to 0..ptr-1.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < 32'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared adder with multi-word carry chaining and a one-deep result stage.
// Define ADDER_ARB_OVF_EN to build the signed-overflow flag on last words.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned ID_W  = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    input  logic [NREQ-1:0]       req_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_co,
    output logic                  res_last,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_ovf
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, owner_q, ptr_next;
    logic             carry_q, sub_q;
    out_stage_t       out_q;
    logic             out_valid_q;

    logic [NREQ-1:0]  owner_mask, arb_req, gnt;
    logic [ID_W-1:0]  arb_ptr, gnt_idx;
    logic             out_free, accept, first_word;
    logic [WIDTH-1:0] a_sel, b_sel, b_eff, sum;
    logic             sub_sel, last_sel, sub_eff, cin, co, ovf;

    assign out_free   = !out_valid_q | res_ready;
    assign first_word = (state_q == IDLE);
    assign accept     = (|gnt) & out_free;

    // In LOCK only the owner may win; pointing the arbiter at it keeps one grant path.
    always_comb begin
        owner_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            owner_mask[i] = (owner_q == ID_W'(i));
        end
        arb_req = first_word ? req_valid : (req_valid & owner_mask);
        arb_ptr = first_word ? rr_ptr_q : owner_q;
    end

    rr_arbiter #(
        .NREQ(NREQ),
        .ID_W(ID_W)
    ) u_rr_arbiter (
        .req(arb_req),
        .ptr(arb_ptr),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        sub_sel  = 1'b0;
        last_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_sel    = req_a[i*WIDTH +: WIDTH];
                b_sel    = req_b[i*WIDTH +: WIDTH];
                sub_sel  = req_sub[i];
                last_sel = req_last[i];
            end
        end
    end

    assign sub_eff = first_word ? sub_sel : sub_q;
    assign cin     = first_word ? sub_sel : carry_q;
    assign b_eff   = sub_eff ? ~b_sel : b_sel;

    adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a(a_sel),
        .b(b_eff),
        .cin(cin),
        .sum(sum),
        .co(co)
    );

`ifdef ADDER_ARB_OVF_EN
    assign ovf = last_sel & (a_sel[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_sel[WIDTH-1]);
`else
    assign ovf = 1'b0;
`endif

    assign ptr_next = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = last_sel ? IDLE : LOCK;
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            req_ready = gnt & {NREQ{out_free}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= '{data: sum, co: co, last: last_sel, id: gnt_idx, ovf: ovf};
            sub_q       <= sub_eff;
            if (last_sel) begin
                rr_ptr_q <= ptr_next;
                carry_q  <= 1'b0;
            end else begin
                owner_q  <= gnt_idx;
                carry_q  <= co;
            end
        end else if (res_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign res_valid = out_valid_q;
    assign res_data  = out_q.data;
    assign res_co    = out_q.co;
    assign res_last  = out_q.last;
    assign res_id    = out_q.id;
    assign res_ovf   = out_q.ovf;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: single-word vector table, scoreboard queue and
// hand-written sequences for carry chaining, backpressure, reset and round robin.
module tb_adder_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef ADDER_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        co;
        logic        last;
        logic [1:0]  id;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] data;
        logic        co;
        logic        ovf;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic [N-1:0]   req_last;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_co;
    logic           res_last;
    logic [IW-1:0]  res_id;
    logic           res_ovf;

    int   tests;
    int   fails;
    exp_t sb[$];

    adder_arbiter #(
        .WIDTH(W),
        .NREQ(N),
        .ID_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_sub(req_sub),
        .req_last(req_last),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_co(res_co),
        .res_last(res_last),
        .res_id(res_id),
        .res_ovf(res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin, input logic last);
        logic [15:0] be;
        logic [16:0] s;
        exp_t        e;
        be     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, be} + 17'(cin);
        e.data = s[15:0];
        e.co   = s[16];
        e.last = last;
        e.id   = 2'(id);
        e.ovf  = OVF_EN && last && (a[15] == be[15]) && (s[15] != a[15]);
        return e;
    endfunction

    // Called once per cycle, shortly after the negedge where inputs were set.
    task automatic sample();
        exp_t e;
        #1;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got id %0d data %0h, expected no result", res_id,
                         res_data);
            end else begin
                e = sb.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_co", 32'(res_co), 32'(e.co));
                chk("res_last", 32'(res_last), 32'(e.last));
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end
        end
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic last);
        req_valid[id]     = 1'b1;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_sub[id]       = sub;
        req_last[id]      = last;
    endtask

    // Enter at a fresh negedge; returns in the cycle the word is accepted.
    task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic last, input exp_t e);
        bit done;
        done = 1'b0;
        set_req(id, a, b, sub, last);
        for (int k = 0; k < 16 && !done; k++) begin
            if (k > 0) @(negedge clk);
            sample();
            if (req_ready[id]) begin
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: requester %0d not granted, expected grant in 16 cycles",
                     id);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        chk("ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_co", 32'(res_co), 0);
        chk("rst_last", 32'(res_last), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_ovf", 32'(res_ovf), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        sb.delete();
        sample();
    endtask

    vec_t        vecs[6];
    logic [15:0] ra[4];
    logic [15:0] rb[4];

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_last  = '0;

        vecs[0] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_EN};
        vecs[3] = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_EN};
        vecs[4] = '{3, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};

        do_reset();

        // Single-word table with one-cycle latency checks.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1,
                 '{vecs[i].data, vecs[i].co, 1'b1, 2'(vecs[i].id), vecs[i].ovf});
            @(negedge clk);
            req_valid = '0;
            sample();
            chk("lat_valid", 32'(res_valid), 1);
            chk("lat_data", 32'(res_data), 32'(vecs[i].data));
        end

        // Two-word add on req 2 (ptr now 2); req 1 held off, owner stalls mid-transaction.
        @(negedge clk);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        set_req(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        sample();
        chk("lock_first_grant", 32'(req_ready), 4);
        sb.push_back('{16'h0000, 1'b1, 1'b0, 2'd2, 1'b0});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid[2] = 1'b0;
            sample();
            chk("lock_hold_off", 32'(req_ready), 0);
        end
        @(negedge clk);
        set_req(2, 16'h0001, 16'h0000, 1'b1, 1'b1);
        sample();
        chk("lock_second_grant", 32'(req_ready), 4);
        sb.push_back('{16'h0002, 1'b0, 1'b1, 2'd2, 1'b0});
        @(negedge clk);
        req_valid[2] = 1'b0;
        sample();
        chk("lock_release_grant", 32'(req_ready), 2);
        sb.push_back('{16'h0030, 1'b0, 1'b1, 2'd1, 1'b0});
        @(negedge clk);
        req_valid = '0;
        sample();
        chk("lock_idle_ready", 32'(req_ready), 0);

        // Backpressure: result held for 3 cycles, then push and pop in one cycle.
        @(negedge clk);
        res_ready = 1'b0;
        set_req(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
        sample();
        chk("bp_first_ready", 32'(req_ready), 1);
        sb.push_back('{16'h0002, 1'b0, 1'b1, 2'd0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid[0] = 1'b0;
                set_req(3, 16'h0100, 16'h0023, 1'b0, 1'b1);
            end
            sample();
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data", 32'(res_data), 32'h0002);
            chk("bp_id", 32'(res_id), 0);
            chk("bp_ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        sample();
        chk("bp_release_ready", 32'(req_ready), 8);
        sb.push_back('{16'h0123, 1'b0, 1'b1, 2'd3, 1'b0});
        @(negedge clk);
        req_valid = '0;
        sample();

        // Reset in the middle of a LOCK with a non-zero round-robin pointer.
        @(negedge clk);
        send(1, 16'h0040, 16'h0002, 1'b0, 1'b1, '{16'h0042, 1'b0, 1'b1, 2'd1, 1'b0});
        @(negedge clk);
        req_valid = '0;
        sample();
        @(negedge clk);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        sample();
        chk("rl_first_grant", 32'(req_ready), 4);
        sb.push_back('{16'h0000, 1'b1, 1'b0, 2'd2, 1'b0});
        @(negedge clk);
        req_valid = '0;
        sample();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 16'h0005, 16'h0003, 1'b0, 1'b1);
        set_req(2, 16'h0005, 16'h0003, 1'b1, 1'b1);
        sample();
        chk("rl_ready_in_reset", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        chk("rl_valid", 32'(res_valid), 0);
        chk("rl_grant_ptr0", 32'(req_ready), 1);
        sb.push_back('{16'h0008, 1'b0, 1'b1, 2'd0, 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        sample();
        chk("rl_next_grant", 32'(req_ready), 4);
        sb.push_back('{16'h0002, 1'b1, 1'b1, 2'd2, 1'b0});
        @(negedge clk);
        req_valid = '0;
        sample();

        // Round robin from a fresh reset: all requesters busy, one result per cycle.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            ra[i] = 16'(32'h1111 * (i + 1));
            rb[i] = 16'(32'hF00F + i);
            set_req(i, ra[i], rb[i], 1'b0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            sample();
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
            sb.push_back(model(k % N, ra[k % N], rb[k % N], 1'b0, 1'b0, 1'b1));
            if (k > 0) chk("rr_throughput", 32'(res_valid), 1);
        end
        @(negedge clk);
        req_valid = '0;
        sample();
        @(negedge clk);
        sample();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
